// File: rtl/mo_cart_loader_if.sv
// Byte-stream (HPS ioctl) and DDRAM single-beat write channel used by the cartridge loader.
// master is the loader's view; slave is the view of the HPS/DDRAM side.
interface mo_cart_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        ddram_busy;
    logic        ddram_we;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din;
    logic [7:0]  ddram_be;
    logic [7:0]  ddram_burstcnt;

    modport master (
        input  ioctl_download,
        input  ioctl_index,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        output ioctl_wait,
        input  ddram_busy,
        output ddram_we,
        output ddram_addr,
        output ddram_din,
        output ddram_be,
        output ddram_burstcnt
    );

    modport slave (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        input  ioctl_wait,
        output ddram_busy,
        input  ddram_we,
        input  ddram_addr,
        input  ddram_din,
        input  ddram_be,
        input  ddram_burstcnt
    );
endinterface

// File: rtl/mo_cart_loader.sv
// Packs HPS cartridge download bytes into 64-bit DDRAM words with byte enables,
// stalls the HPS while a word write is outstanding, and reports cartridge presence/size.
module mo_cart_loader #(
    parameter logic [7:0]  INDEX     = 8'd1,
    parameter logic [28:0] BASE_ADDR = 29'h1E000000
) (
    input  logic             clk_sys,
    input  logic             reset,
    mo_cart_loader_if.master bus,
    output logic             cart_loaded,
    output logic [24:0]      cart_size
);
    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

    state_e      r_state;
    state_e      r_ret;
    logic        r_we;
    logic [28:0] r_addr;
    logic [63:0] r_din;
    logic [7:0]  r_be;
    logic        r_pend_valid;
    logic [24:0] r_pend_addr;
    logic [7:0]  r_pend_data;
    logic        r_start_prev;
    logic        r_loaded;
    logic [24:0] r_size;

    logic        w_start;
    logic        w_take;
    logic        w_fits;
    logic        w_accept;
    logic [24:0] w_src_addr;
    logic [24:0] w_src_size;
    logic [7:0]  w_src_data;
    logic [2:0]  w_lane;
    logic [28:0] w_src_word;

    assign w_start    = bus.ioctl_download & (bus.ioctl_index == INDEX);
    // A parked byte always wins over the live strobe; the HPS is stalled while it is parked.
    assign w_src_addr = r_pend_valid ? r_pend_addr : bus.ioctl_addr;
    assign w_src_data = r_pend_valid ? r_pend_data : bus.ioctl_dout;
    assign w_src_size = w_src_addr + 25'd1;
    assign w_lane     = w_src_addr[2:0];
    assign w_src_word = BASE_ADDR + {7'd0, w_src_addr[24:3]};
    assign w_fits     = (r_be == 8'd0) | (w_src_word == r_addr);
    assign w_take     = r_pend_valid | bus.ioctl_wr;
    assign w_accept   = r_we & ~bus.ddram_busy;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= StIdle;
            r_ret        <= StIdle;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_be         <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_start_prev <= 1'b0;
            r_loaded     <= 1'b0;
            r_size       <= '0;
        end else begin
            r_start_prev <= w_start;
            unique case (r_state)
                StIdle: begin
                    if (w_start && !r_start_prev) begin
                        r_din        <= '0;
                        r_be         <= '0;
                        r_pend_valid <= 1'b0;
                        r_loaded     <= 1'b0;
                        r_size       <= '0;
                        r_state      <= StFill;
                    end
                end
                StFill: begin
                    if (w_take) begin
                        if (w_fits) begin
                            r_din[{w_lane, 3'b000} +: 8] <= w_src_data;
                            r_be[w_lane]                 <= 1'b1;
                            r_addr                       <= w_src_word;
                            r_pend_valid                 <= 1'b0;
                            if (w_src_size > r_size) begin
                                r_size <= w_src_size;
                            end
                            if (w_lane == 3'd7) begin
                                r_we    <= 1'b1;
                                r_ret   <= StFill;
                                r_state <= StWrite;
                            end
                        end else begin
                            // Different word: park the byte and flush the current one first.
                            r_pend_valid <= 1'b1;
                            r_pend_addr  <= bus.ioctl_addr;
                            r_pend_data  <= bus.ioctl_dout;
                            r_we         <= 1'b1;
                            r_ret        <= StFill;
                            r_state      <= StWrite;
                        end
                    end else if (!bus.ioctl_download) begin
                        if (r_be != 8'd0) begin
                            r_we    <= 1'b1;
                            r_ret   <= StDone;
                            r_state <= StWrite;
                        end else begin
                            r_state <= StDone;
                        end
                    end
                end
                StWrite: begin
                    if (w_accept) begin
                        r_we  <= 1'b0;
                        r_din <= '0;
                        r_be  <= '0;
                        // A download that ended during the flush goes straight to DONE.
                        if (r_ret == StDone || (!r_pend_valid && !bus.ioctl_download)) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StFill;
                        end
                    end
                end
                StDone: begin
                    r_loaded <= (r_size != 25'd0);
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.ioctl_wait     = (r_state == StWrite) | r_pend_valid;
    assign bus.ddram_we       = r_we;
    assign bus.ddram_addr     = r_addr;
    assign bus.ddram_din      = r_din;
    assign bus.ddram_be       = r_be;
    assign bus.ddram_burstcnt = 8'd1;
    assign cart_loaded        = r_loaded;
    assign cart_size          = r_size;
endmodule

// File: tb/tb_mo_cart_loader.sv
// Scoreboard bench for mo_cart_loader: a byte-level reference model queues expected DDRAM
// writes, and a negedge monitor pops and compares every accepted write.
module tb_mo_cart_loader;
    localparam logic [28:0] Base = 29'h1E000000;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cart_loaded;
    logic [24:0] cart_size;

    mo_cart_loader_if bus ();

    mo_cart_loader #(
        .INDEX    (8'd1),
        .BASE_ADDR(Base)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus.master),
        .cart_loaded(cart_loaded),
        .cart_size  (cart_size)
    );

    always #5 clk_sys = ~clk_sys;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        busy_rand = 1'b0;

    // Reference model: the word currently being collected plus load bookkeeping.
    bit          m_have;
    logic [21:0] m_word;
    logic [63:0] m_din;
    logic [7:0]  m_be;
    int unsigned m_size;
    bit          m_loaded;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void model_flush();
        wr_t w;
        w.addr = Base + {7'd0, m_word};
        w.din  = m_din;
        w.be   = m_be;
        exp_q.push_back(w);
        m_have = 1'b0;
        m_din  = '0;
        m_be   = '0;
    endfunction

    function automatic void model_byte(input logic [24:0] a, input logic [7:0] d);
        if (m_have && a[24:3] != m_word) model_flush();
        m_have                 = 1'b1;
        m_word                 = a[24:3];
        m_din[a[2:0]*8 +: 8]   = d;
        m_be[a[2:0]]           = 1'b1;
        if (int'(a) + 1 > m_size) m_size = int'(a) + 1;
        if (a[2:0] == 3'd7) model_flush();
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (busy_rand) bus.ddram_busy = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.ioctl_wait && n < 300) begin
            tick();
            n++;
        end
        if (bus.ioctl_wait) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=1 required=0");
        end
        if (bus.ioctl_index == 8'd1) model_byte(a, d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        tick();
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        if (idx == 8'd1) begin
            m_have   = 1'b0;
            m_din    = '0;
            m_be     = '0;
            m_size   = 0;
            m_loaded = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic end_dl();
        int n = 0;
        bus.ioctl_download = 1'b0;
        if (bus.ioctl_index == 8'd1) begin
            if (m_have) model_flush();
            m_loaded = (m_size != 0);
        end
        tick();
        while ((exp_q.size() != 0 || bus.ioctl_wait) && n < 300) begin
            tick();
            n++;
        end
        check("drain_pending_writes", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        check("cart_size", 64'(cart_size), 64'(m_size));
        check("cart_loaded", 64'(cart_loaded), 64'(m_loaded));
    endtask

    // Monitor: pops on every accepted write and checks stability while stalled.
    wr_t  hold;
    logic hold_v = 1'b0;
    wr_t  e;
    always @(negedge clk_sys) begin
        if (hold_v && bus.ddram_we && !reset) begin
            check("stall_addr_stable", 64'(bus.ddram_addr), 64'(hold.addr));
            check("stall_din_stable", bus.ddram_din, hold.din);
            check("stall_be_stable", 64'(bus.ddram_be), 64'(hold.be));
        end
        if (!reset && bus.ddram_we && !bus.ddram_busy) begin
            check("wait_during_write", 64'(bus.ioctl_wait), 64'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h required=none", bus.ddram_addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(bus.ddram_addr), 64'(e.addr));
                check("write_din", bus.ddram_din, e.din);
                check("write_be", 64'(bus.ddram_be), 64'(e.be));
            end
        end
        hold_v    = bus.ddram_we && bus.ddram_busy && !reset;
        hold.addr = bus.ddram_addr;
        hold.din  = bus.ddram_din;
        hold.be   = bus.ddram_be;
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_wait"}, 64'(bus.ioctl_wait), 64'd0);
        check({tag, "_we"}, 64'(bus.ddram_we), 64'd0);
        check({tag, "_addr"}, 64'(bus.ddram_addr), 64'd0);
        check({tag, "_din"}, bus.ddram_din, 64'd0);
        check({tag, "_be"}, 64'(bus.ddram_be), 64'd0);
        check({tag, "_loaded"}, 64'(cart_loaded), 64'd0);
        check({tag, "_size"}, 64'(cart_size), 64'd0);
        check({tag, "_burstcnt"}, 64'(bus.ddram_burstcnt), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.ddram_busy     = 1'b0;
        m_have = 1'b0; m_din = '0; m_be = '0; m_size = 0; m_loaded = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();

        // Full words: 16 sequential bytes.
        start_dl(8'd1);
        for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i));
        end_dl();
        check("full_size16", 64'(cart_size), 64'd16);
        check("full_loaded", 64'(cart_loaded), 64'd1);

        // Partial tail.
        start_dl(8'd1);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        end_dl();
        check("tail_size3", 64'(cart_size), 64'd3);

        // Busy backpressure on the lane-7 write.
        start_dl(8'd1);
        for (int i = 0; i < 7; i++) send_byte(25'(i), 8'($urandom));
        bus.ddram_busy = 1'b1;
        send_byte(25'd7, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            check("busy_wait_high", 64'(bus.ioctl_wait), 64'd1);
            check("busy_we_high", 64'(bus.ddram_we), 64'd1);
            tick();
        end
        bus.ddram_busy = 1'b0;
        tick();
        check("busy_wait_release", 64'(bus.ioctl_wait), 64'd0);
        end_dl();

        // Address jump forces a flush of a partial word.
        start_dl(8'd1);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        send_byte(25'h20, 8'h33);
        check("jump_wait", 64'(bus.ioctl_wait), 64'd1);
        end_dl();
        check("jump_size", 64'(cart_size), 64'h21);

        // Ignored index: nothing happens, cart state kept.
        start_dl(8'd0);
        for (int i = 0; i < 10; i++) begin
            send_byte(25'(i), 8'($urandom));
            check("ignored_wait", 64'(bus.ioctl_wait), 64'd0);
            check("ignored_we", 64'(bus.ddram_we), 64'd0);
        end
        end_dl();

        // Reset while a write is stalled.
        start_dl(8'd1);
        bus.ddram_busy = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(25'(i), 8'($urandom));
        tick();
        tick();
        check("stalled_we", 64'(bus.ddram_we), 64'd1);
        reset = 1'b1;
        tick();
        check_reset_values("midreset");
        exp_q.delete();
        m_have = 1'b0; m_din = '0; m_be = '0; m_size = 0; m_loaded = 1'b0;
        reset              = 1'b0;
        bus.ddram_busy     = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        start_dl(8'd1);
        for (int i = 0; i < 8; i++) send_byte(25'(i), 8'($urandom));
        end_dl();

        // Randomized loads with jumps, lane rewrites, gaps and random busy.
        busy_rand = 1'b1;
        for (int t = 0; t < 8; t++) begin
            int unsigned len;
            int unsigned r;
            logic [24:0] a;
            start_dl(8'd1);
            len = $urandom_range(1, 40);
            a   = 25'($urandom_range(0, 63));
            for (int i = 0; i < int'(len); i++) begin
                send_byte(a, 8'($urandom));
                r = $urandom_range(0, 9);
                if (r == 0) a = 25'($urandom_range(0, 255));
                else if (r != 1) a = a + 25'd1;
                repeat ($urandom_range(0, 2)) tick();
            end
            end_dl();
        end
        busy_rand      = 1'b0;
        bus.ddram_busy = 1'b0;
        tick();
        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
